conv_frame_loader: RTL and testbench

Byte-stream loader that fills the 3x3 kernel and 5x5 image register arrays consumed by the `convolution` block, then holds them stable until the consumer acknowledges. It is the writer side of the `image`/`kernel` array interface: upstream delivers a framed valid/ready byte stream, and `conv_frame_loader` deserialises it into row-major arrays and presents a complete frame with a valid/ack handshake.

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_frame_loader.sv | 139 +++++++++++++
 tb/tb_conv_frame_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Constants and loader state type shared by the convolution datapath and the
// frame loader that fills its kernel/image register arrays.
package conv_pkg;

    localparam int DATA_W  = 8;
    localparam int IMG_DIM = 5;
    localparam int K_DIM   = 3;
    localparam int IMG_N   = IMG_DIM * IMG_DIM;
    localparam int K_N     = K_DIM * K_DIM;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        K_LOAD = 2'd0,
        I_LOAD = 2'd1,
        HOLD   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/conv_frame_loader.sv
// Deserialises a framed byte stream into row-major kernel/image arrays and holds
// the completed frame until the consumer acknowledges it.
module conv_frame_loader
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic                 reuse_kernel,
    output logic [DATA_W-1:0]    image [0:IMG_N-1],
    output logic [DATA_W-1:0]    kernel [0:K_N-1],
    output logic                 frame_valid,
    input  logic                 frame_ack,
    output logic                 err,
    output loader_state_e        dbg_state_o,
    output logic [IDX_W-1:0]     dbg_idx_o
);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready depends on the state register only, never on in_valid.
    localparam int KIDX_W = $clog2(K_N);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(K_N - 1);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(IMG_N - 1);

    loader_state_e      state_q, state_d;
    loader_state_e      start_q, start_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               frame_valid_q, frame_valid_d;
    logic               kernel_we, image_we, accept;
    logic [DATA_W-1:0]  kernel_q [0:K_N-1];
    logic [DATA_W-1:0]  image_q [0:IMG_N-1];

    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        idx_d     = idx_q;
        err_d     = 1'b0;
        kernel_we = 1'b0;
        image_we  = 1'b0;
        case (state_q)
            K_LOAD: begin
                if (accept) begin
                    kernel_we = 1'b1;
                    // A kernel beat is never the last beat of a frame.
                    if (in_last) begin
                        err_d   = 1'b1;
                        state_d = start_q;
                        idx_d   = '0;
                    end else if (idx_q == K_LAST) begin
                        state_d = I_LOAD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            I_LOAD: begin
                if (accept) begin
                    image_we = 1'b1;
                    if (idx_q == I_LAST) begin
                        state_d = HOLD;
                        idx_d   = '0;
                        err_d   = !in_last;
                    end else if (in_last) begin
                        err_d   = 1'b1;
                        state_d = start_q;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d = reuse_kernel ? I_LOAD : K_LOAD;
                    start_d = state_d;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = K_LOAD;
                start_d = K_LOAD;
                idx_d   = '0;
            end
        endcase
        in_ready_d    = (state_d != HOLD);
        frame_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= K_LOAD;
            start_q       <= K_LOAD;
            idx_q         <= '0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b1;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            in_ready_q    <= in_ready_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K_N; i++) kernel_q[i] <= '0;
        end else if (kernel_we) begin
            kernel_q[idx_q[KIDX_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_N; i++) image_q[i] <= '0;
        end else if (image_we) begin
            image_q[idx_q] <= in_data;
        end
    end

    assign kernel      = kernel_q;
    assign image       = image_q;
    assign in_ready    = in_ready_q;
    assign frame_valid = frame_valid_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;
    assign dbg_idx_o   = idx_q;

endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader: framing, backpressure, kernel reuse,
// framing errors and asynchronous reset.
module tb_conv_frame_loader;
    import conv_pkg::*;

    logic                clk;
    logic                rst_n;
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic                reuse_kernel;
    logic [DATA_W-1:0]   image [0:IMG_N-1];
    logic [DATA_W-1:0]   kernel [0:K_N-1];
    logic                frame_valid;
    logic                frame_ack;
    logic                err;
    loader_state_e       dbg_state;
    logic [IDX_W-1:0]    dbg_idx;

    int checks = 0;
    int errors = 0;
    int err_count = 0;
    logic [DATA_W-1:0] exp_kernel [0:K_N-1];

    conv_frame_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .reuse_kernel (reuse_kernel),
        .image        (image),
        .kernel       (kernel),
        .frame_valid  (frame_valid),
        .frame_ack    (frame_ack),
        .err          (err),
        .dbg_state_o  (dbg_state),
        .dbg_idx_o    (dbg_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (err === 1'b1) err_count++;

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
        int waited = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_beat_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] base, input int n, input bit with_last);
        for (int i = 0; i < n; i++)
            send_beat(DATA_W'(base + i), (with_last && i == n - 1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic ack(input logic reuse);
        reuse_kernel = reuse;
        frame_ack    = 1'b1;
        @(posedge clk); #1;
        frame_ack    = 1'b0;
        reuse_kernel = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++;
        if (dbg_state !== K_LOAD || dbg_idx !== 5'd0) begin
            errors++; $display("FAIL reset_state: got state=%0d idx=%0d want 0/0", dbg_state, dbg_idx);
        end
        for (int i = 0; i < K_N; i++) begin
            checks++;
            if (kernel[i] !== 8'h00) begin errors++; $display("FAIL reset_kernel[%0d]: got %h want 00", i, kernel[i]); end
        end
        for (int i = 0; i < IMG_N; i++) begin
            checks++;
            if (image[i] !== 8'h00) begin errors++; $display("FAIL reset_image[%0d]: got %h want 00", i, image[i]); end
        end
    endtask

    task automatic test_normal_frame;
        int e0 = err_count;
        send_frame(8'd1, 34, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL normal_hold: frame_valid=%b in_ready=%b want 1/0", frame_valid, in_ready);
        end
        for (int i = 0; i < K_N; i++) begin
            exp_kernel[i] = 8'(i + 1);
            checks++;
            if (kernel[i] !== exp_kernel[i]) begin errors++; $display("FAIL normal_kernel[%0d]: got %h want %h", i, kernel[i], exp_kernel[i]); end
        end
        for (int i = 0; i < IMG_N; i++) begin
            checks++;
            if (image[i] !== 8'(i + 10)) begin errors++; $display("FAIL normal_image[%0d]: got %h want %h", i, image[i], 8'(i + 10)); end
        end
        checks++;
        if (err_count !== e0) begin errors++; $display("FAIL normal_err: got %0d pulses want 0", err_count - e0); end
    endtask

    task automatic test_backpressure;
        in_data  = 8'h55;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || frame_valid !== 1'b1 || kernel[0] !== 8'h01 || image[0] !== 8'h0a) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: in_ready=%b fv=%b k0=%h i0=%h want 0/1/01/0a",
                         c, in_ready, frame_valid, kernel[0], image[0]);
            end
        end
        ack(1'b0);
        checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1 || kernel[0] !== 8'h01) begin
            errors++; $display("FAIL bp_after_ack: fv=%b in_ready=%b k0=%h want 0/1/01", frame_valid, in_ready, kernel[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (kernel[0] !== 8'h55 || dbg_idx !== 5'd1 || dbg_state !== K_LOAD) begin
            errors++; $display("FAIL bp_accept: k0=%h idx=%0d state=%0d want 55/1/0", kernel[0], dbg_idx, dbg_state);
        end
        for (int i = 1; i < K_N; i++) send_beat(8'(i + 1), 1'b0);
        send_frame(8'd10, 25, 1'b1);
        exp_kernel[0] = 8'h55;
        checks++;
        if (frame_valid !== 1'b1 || kernel[0] !== 8'h55 || kernel[8] !== 8'h09 || image[24] !== 8'd34) begin
            errors++; $display("FAIL bp_frame: fv=%b k0=%h k8=%h i24=%h want 1/55/09/22", frame_valid, kernel[0], kernel[8], image[24]);
        end
    endtask

    task automatic test_reuse_kernel;
        int e0 = err_count;
        ack(1'b1);
        checks++;
        if (dbg_state !== I_LOAD || in_ready !== 1'b1) begin
            errors++; $display("FAIL reuse_state: state=%0d in_ready=%b want 1/1", dbg_state, in_ready);
        end
        send_frame(8'hA0, 25, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || image[0] !== 8'hA0 || image[24] !== 8'hB8) begin
            errors++; $display("FAIL reuse_image: fv=%b i0=%h i24=%h want 1/a0/b8", frame_valid, image[0], image[24]);
        end
        for (int i = 0; i < K_N; i++) begin
            checks++;
            if (kernel[i] !== exp_kernel[i]) begin errors++; $display("FAIL reuse_kernel[%0d]: got %h want %h", i, kernel[i], exp_kernel[i]); end
        end
        checks++;
        if (err_count !== e0) begin errors++; $display("FAIL reuse_err: got %0d pulses want 0", err_count - e0); end
        ack(1'b0);
    endtask

    task automatic test_early_last;
        for (int i = 0; i < 4; i++) send_beat(8'(8'h21 + i), 1'b0);
        send_beat(8'h25, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (err !== 1'b1 || dbg_state !== K_LOAD || dbg_idx !== 5'd0 || frame_valid !== 1'b0) begin
            errors++; $display("FAIL early_err: err=%b state=%0d idx=%0d fv=%b want 1/0/0/0", err, dbg_state, dbg_idx, frame_valid);
        end
        checks++;
        if (kernel[4] !== 8'h25) begin errors++; $display("FAIL early_written: k4=%h want 25", kernel[4]); end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL early_pulse_width: err=%b want 0", err); end
        send_frame(8'h40, 34, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL early_recover: fv=%b err=%b want 1/0", frame_valid, err);
        end
        for (int i = 0; i < K_N; i++) begin
            checks++;
            if (kernel[i] !== 8'(8'h40 + i)) begin errors++; $display("FAIL early_kernel[%0d]: got %h want %h", i, kernel[i], 8'(8'h40 + i)); end
        end
        checks++;
        if (image[0] !== 8'h49 || image[24] !== 8'h61) begin
            errors++; $display("FAIL early_image: i0=%h i24=%h want 49/61", image[0], image[24]);
        end
        ack(1'b0);
    endtask

    task automatic test_missing_last;
        int e0 = err_count;
        send_frame(8'h80, 34, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL missing_together: fv=%b err=%b want 1/1", frame_valid, err);
        end
        @(posedge clk); #1;
        checks++;
        if (err_count !== e0 + 1 || frame_valid !== 1'b1) begin
            errors++; $display("FAIL missing_pulses: got %0d pulses fv=%b want 1/1", err_count - e0, frame_valid);
        end
        checks++;
        if (kernel[0] !== 8'h80 || kernel[8] !== 8'h88 || image[0] !== 8'h89 || image[24] !== 8'hA1) begin
            errors++; $display("FAIL missing_arrays: k0=%h k8=%h i0=%h i24=%h want 80/88/89/a1",
                               kernel[0], kernel[8], image[0], image[24]);
        end
        ack(1'b0);
    endtask

    task automatic test_reset_mid_frame;
        send_frame(8'hC0, 20, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || dbg_state !== K_LOAD || dbg_idx !== 5'd0) begin
            errors++; $display("FAIL rst_mid_ctrl: fv=%b rdy=%b err=%b state=%0d idx=%0d want 0/1/0/0/0",
                               frame_valid, in_ready, err, dbg_state, dbg_idx);
        end
        for (int i = 0; i < K_N; i++) begin
            checks++;
            if (kernel[i] !== 8'h00) begin errors++; $display("FAIL rst_mid_kernel[%0d]: got %h want 00", i, kernel[i]); end
        end
        for (int i = 0; i < IMG_N; i++) begin
            checks++;
            if (image[i] !== 8'h00) begin errors++; $display("FAIL rst_mid_image[%0d]: got %h want 00", i, image[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || frame_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_release: rdy=%b fv=%b want 1/0", in_ready, frame_valid);
        end
        send_frame(8'd1, 34, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || kernel[0] !== 8'h01 || kernel[8] !== 8'h09 || image[0] !== 8'h0a || image[24] !== 8'h22) begin
            errors++; $display("FAIL rst_mid_reload: fv=%b k0=%h k8=%h i0=%h i24=%h want 1/01/09/0a/22",
                               frame_valid, kernel[0], kernel[8], image[0], image[24]);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        reuse_kernel = 1'b0;
        frame_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_normal_frame();
        test_backpressure();
        test_reuse_kernel();
        test_early_last();
        test_missing_last();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
